// File: rtl/tape_pkg.sv
// Shared types and constants for the CAS tape transport controller and its
// buffer-memory arbiter.
package tape_pkg;

   typedef enum logic [2:0] {
      EMPTY,
      LOADING,
      REWIND,
      READY,
      PLAYING
   } tape_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_LOAD,
      GNT_PLAY
   } grant_t;

   localparam int unsigned MOTOR_HOLD_DEF  = 53000;
   localparam int unsigned CE_HZ           = 5369318;
   localparam int unsigned BAUD_1200_TICKS = 4474;
   localparam int unsigned BAUD_2400_TICKS = 2237;

   // Memory owner for a given transport state.
   function automatic grant_t grant_of(input tape_state_t st);
      case (st)
         LOADING:                 return GNT_LOAD;
         REWIND, READY, PLAYING:  return GNT_PLAY;
         default:                 return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tape_mem_arb.sv
// Single-port buffer memory arbiter: one outstanding request, loader writes
// or player reads depending on the grant supplied by the transport FSM.
module tape_mem_arb
   import tape_pkg::*;
#(
   parameter int unsigned ADDR_W = 27
) (
   input  logic              clk,
   input  logic              reset_n,
   input  grant_t            grant,
   input  logic              ld_wr,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              wr_take_c,
   output logic              ld_wait,
   input  logic [ADDR_W-1:0] ram_a,
   input  logic              ram_rd,
   output logic [7:0]        ram_di,
   output logic              buff_mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);

   logic              rd_go;
   logic              wq_valid, wq_valid_n;
   logic [ADDR_W-1:0] wq_addr, wq_addr_n, mem_addr_n;
   logic [7:0]        wq_data, wq_data_n, mem_wdata_n, ram_di_n;
   logic              mem_we_n, mem_rd_n, ld_wait_n, bmr_n;

   // Next-state of the request channel; a write taken while a read is in
   // flight waits in the one-entry queue until the bus is free.
   always_comb begin
      rd_go       = ram_rd && buff_mem_ready && (grant == GNT_PLAY);
      wr_take_c   = ld_wr && !ld_wait && (grant == GNT_LOAD);
      wq_valid_n  = wq_valid;
      wq_addr_n   = wq_addr;
      wq_data_n   = wq_data;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      mem_we_n    = mem_we;
      mem_rd_n    = mem_rd;
      ld_wait_n   = ld_wait;
      ram_di_n    = ram_di;

      if (mem_rd && mem_ack) begin
         mem_rd_n = 1'b0;
         if (grant == GNT_PLAY) ram_di_n = mem_rdata;
      end
      if (mem_we && mem_ack) begin
         mem_we_n  = 1'b0;
         ld_wait_n = 1'b0;
      end
      if (rd_go) begin
         mem_rd_n   = 1'b1;
         mem_addr_n = ram_a;
      end
      if (wr_take_c) begin
         ld_wait_n  = 1'b1;
         wq_valid_n = 1'b1;
         wq_addr_n  = ld_addr;
         wq_data_n  = ld_data;
      end
      if (wq_valid_n && !mem_rd_n && !mem_we_n) begin
         mem_we_n    = 1'b1;
         mem_addr_n  = wq_addr_n;
         mem_wdata_n = wq_data_n;
         wq_valid_n  = 1'b0;
      end
      bmr_n = (grant == GNT_PLAY) && !mem_rd_n && !ld_wait_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wq_valid       <= 1'b0;
         wq_addr        <= '0;
         wq_data        <= '0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_we         <= 1'b0;
         mem_rd         <= 1'b0;
         ld_wait        <= 1'b0;
         ram_di         <= '0;
         buff_mem_ready <= 1'b0;
      end else begin
         wq_valid       <= wq_valid_n;
         wq_addr        <= wq_addr_n;
         wq_data        <= wq_data_n;
         mem_addr       <= mem_addr_n;
         mem_wdata      <= mem_wdata_n;
         mem_we         <= mem_we_n;
         mem_rd         <= mem_rd_n;
         ld_wait        <= ld_wait_n;
         ram_di         <= ram_di_n;
         buff_mem_ready <= bmr_n;
      end
   end

endmodule

// File: rtl/tape_ctrl.sv
// CAS player transport controller: sequences play/rewind from loader events,
// the cassette motor line and user rewind, and owns the buffer memory grant.
module tape_ctrl
   import tape_pkg::*;
#(
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned MOTOR_HOLD  = MOTOR_HOLD_DEF,
   parameter bit          AUTO_REWIND = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_5m3,
   input  logic              motor,
   input  logic              user_rewind,
   input  logic              ld_start,
   input  logic              ld_wr,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   input  logic              ld_done,
   output logic              ld_wait,
   input  logic [ADDR_W-1:0] ram_a,
   input  logic              ram_rd,
   output logic [7:0]        ram_di,
   output logic              buff_mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              play,
   output logic              rewind,
   output logic              tape_loaded,
   output logic              tape_end
);

   localparam int unsigned HOLD_W = $clog2(MOTOR_HOLD + 1);

   tape_state_t       state;
   grant_t            grant;
   logic [ADDR_W-1:0] size;
   logic [HOLD_W-1:0] hold_cnt;
   logic              rew_q;
   logic              rew_rise;
   logic              wr_take_c;

   always_comb begin
      grant    = grant_of(state);
      rew_rise = user_rewind && !rew_q;
   end

   // Transport FSM; ld_start outranks every other event, rewind outranks motor.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= EMPTY;
         size        <= '0;
         hold_cnt    <= '0;
         rew_q       <= 1'b0;
         play        <= 1'b0;
         rewind      <= 1'b0;
         tape_loaded <= 1'b0;
         tape_end    <= 1'b0;
      end else begin
         rew_q  <= user_rewind;
         rewind <= 1'b0;
         if (wr_take_c && ((ld_addr + ADDR_W'(1)) > size))
            size <= ld_addr + ADDR_W'(1);

         if (ld_start) begin
            state       <= LOADING;
            size        <= '0;
            hold_cnt    <= '0;
            play        <= 1'b0;
            tape_loaded <= 1'b0;
            tape_end    <= 1'b0;
         end else begin
            case (state)
               EMPTY: ;
               LOADING: begin
                  if (ld_done) begin
                     if (size == '0) begin
                        state <= EMPTY;
                     end else begin
                        tape_loaded <= 1'b1;
                        if (AUTO_REWIND) begin
                           state  <= REWIND;
                           rewind <= 1'b1;
                        end else begin
                           state <= READY;
                        end
                     end
                  end
               end
               REWIND: state <= READY;
               READY: begin
                  if (rew_rise) begin
                     state    <= REWIND;
                     rewind   <= 1'b1;
                     tape_end <= 1'b0;
                  end else if (motor && !tape_end) begin
                     state    <= PLAYING;
                     play     <= 1'b1;
                     hold_cnt <= '0;
                  end
               end
               PLAYING: begin
                  if (rew_rise) begin
                     state    <= REWIND;
                     rewind   <= 1'b1;
                     tape_end <= 1'b0;
                     play     <= 1'b0;
                  end else if (ram_a >= size) begin
                     state    <= READY;
                     tape_end <= 1'b1;
                     play     <= 1'b0;
                  end else if (motor) begin
                     hold_cnt <= '0;
                  end else if (ce_5m3) begin
                     if (hold_cnt == HOLD_W'(MOTOR_HOLD - 1)) begin
                        state <= READY;
                        play  <= 1'b0;
                     end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                     end
                  end
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

   tape_mem_arb #(
      .ADDR_W (ADDR_W)
   ) u_arb (
      .clk            (clk),
      .reset_n        (reset_n),
      .grant          (grant),
      .ld_wr          (ld_wr),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .wr_take_c      (wr_take_c),
      .ld_wait        (ld_wait),
      .ram_a          (ram_a),
      .ram_rd         (ram_rd),
      .ram_di         (ram_di),
      .buff_mem_ready (buff_mem_ready),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_we         (mem_we),
      .mem_rd         (mem_rd),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
   );

endmodule

// File: tb/tb_tape_ctrl.sv
// Directed bench for tape_ctrl: load, play, motor hold, tape end, rewind,
// load abort during a pending read, and reset during a read.
module tb_tape_ctrl;

   localparam int unsigned AW = 27;
   localparam int unsigned MH = 6;
   localparam logic [7:0] IMG [3] = '{8'h3C, 8'hA5, 8'h7E};

   logic          clk = 1'b0;
   logic          reset_n, ce_5m3, motor, user_rewind;
   logic          ld_start, ld_wr, ld_done, ram_rd, mem_ack;
   logic [AW-1:0] ld_addr, ram_a;
   logic [7:0]    ld_data, mem_rdata;
   logic          ld_wait, buff_mem_ready, mem_we, mem_rd;
   logic          play, rewind, tape_loaded, tape_end;
   logic [7:0]    ram_di, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    flags;

   int total = 0;
   int bad   = 0;
   int low_cnt;

   always #5 clk = ~clk;

   assign flags = {play, rewind, tape_loaded, tape_end, ld_wait, buff_mem_ready, mem_we, mem_rd};

   tape_ctrl #(
      .ADDR_W      (AW),
      .MOTOR_HOLD  (MH),
      .AUTO_REWIND (1'b1)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ce_5m3         (ce_5m3),
      .motor          (motor),
      .user_rewind    (user_rewind),
      .ld_start       (ld_start),
      .ld_wr          (ld_wr),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .ld_done        (ld_done),
      .ld_wait        (ld_wait),
      .ram_a          (ram_a),
      .ram_rd         (ram_rd),
      .ram_di         (ram_di),
      .buff_mem_ready (buff_mem_ready),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_we         (mem_we),
      .mem_rd         (mem_rd),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .play           (play),
      .rewind         (rewind),
      .tape_loaded    (tape_loaded),
      .tape_end       (tape_end)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         ce_5m3 = 1'b1;
         step();
         ce_5m3 = 1'b0;
         step();
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b1; ce_5m3 = 1'b0; motor = 1'b0; user_rewind = 1'b0;
      ld_start = 1'b0; ld_wr = 1'b0; ld_done = 1'b0; ram_rd = 1'b0; mem_ack = 1'b0;
      ld_addr = '0; ram_a = '0; ld_data = '0; mem_rdata = '0;
      #2 reset_n = 1'b0;
      step();
      step();
      check("reset_flags", 32'(flags), 32'h0);
      check("reset_ram_di", 32'(ram_di), 32'h0);
      reset_n = 1'b1;
      step();

      // load three bytes, ack on the second cycle of each write
      ld_start = 1'b1; step(); ld_start = 1'b0;
      check("loading_not_loaded", 32'(tape_loaded), 32'h0);
      for (int i = 0; i < 3; i++) begin
         ld_wr = 1'b1; ld_addr = AW'(i); ld_data = IMG[i];
         step();
         ld_wr = 1'b0;
         check("wr_we", 32'(mem_we), 32'h1);
         check("wr_addr", 32'(mem_addr), 32'(i));
         check("wr_data", 32'(mem_wdata), 32'(IMG[i]));
         check("wr_wait1", 32'(ld_wait), 32'h1);
         step();
         check("wr_wait2", 32'(ld_wait), 32'h1);
         check("wr_we_held", 32'(mem_we), 32'h1);
         mem_ack = 1'b1; step(); mem_ack = 1'b0;
         check("wr_done_wait", 32'(ld_wait), 32'h0);
         check("wr_done_we", 32'(mem_we), 32'h0);
      end
      ld_done = 1'b1; step(); ld_done = 1'b0;
      check("auto_rewind", 32'(rewind), 32'h1);
      check("loaded", 32'(tape_loaded), 32'h1);
      step();
      check("rewind_once", 32'(rewind), 32'h0);
      check("ready_bmr", 32'(buff_mem_ready), 32'h1);

      // write outside LOADING is dropped
      ld_wr = 1'b1; ld_addr = AW'(9); step(); ld_wr = 1'b0;
      check("drop_wr_we", 32'(mem_we), 32'h0);
      check("drop_wr_wait", 32'(ld_wait), 32'h0);

      motor = 1'b1; step();
      check("play_on", 32'(play), 32'h1);

      // player read of byte 1, ack three cycles after mem_rd rises
      ram_a = AW'(1); ram_rd = 1'b1; step(); ram_rd = 1'b0;
      check("rd_issue", 32'(mem_rd), 32'h1);
      check("rd_addr", 32'(mem_addr), 32'h1);
      low_cnt = 0;
      if (!buff_mem_ready) low_cnt++;
      step(); if (!buff_mem_ready) low_cnt++;
      step(); if (!buff_mem_ready) low_cnt++;
      step(); if (!buff_mem_ready) low_cnt++;
      check("rd_held", 32'(mem_rd), 32'h1);
      mem_ack = 1'b1; mem_rdata = 8'hA5; step(); mem_ack = 1'b0;
      if (!buff_mem_ready) low_cnt++;
      check("rd_data", 32'(ram_di), 32'hA5);
      check("rd_bmr_back", 32'(buff_mem_ready), 32'h1);
      check("rd_dropped", 32'(mem_rd), 32'h0);
      check("rd_low_cycles", 32'(low_cnt), 32'd4);

      // motor hold window
      motor = 1'b0; ticks(MH - 1);
      check("hold_short", 32'(play), 32'h1);
      motor = 1'b1; step(); motor = 1'b0;
      ticks(MH - 1);
      check("hold_restart", 32'(play), 32'h1);
      ticks(1);
      check("hold_expire", 32'(play), 32'h0);
      motor = 1'b1; step();
      check("replay", 32'(play), 32'h1);

      // tape end at size boundary
      ram_a = AW'(2); step();
      check("end_below", 32'(tape_end), 32'h0);
      check("end_below_play", 32'(play), 32'h1);
      ram_a = AW'(3); step();
      check("end_hit", 32'(tape_end), 32'h1);
      check("end_play_off", 32'(play), 32'h0);
      step();
      check("end_stays_stopped", 32'(play), 32'h0);
      ram_a = '0; user_rewind = 1'b1; step();
      check("user_rewind", 32'(rewind), 32'h1);
      check("rewind_clr_end", 32'(tape_end), 32'h0);
      user_rewind = 1'b0; step();
      check("user_rewind_pulse", 32'(rewind), 32'h0);
      step();
      check("play_after_rewind", 32'(play), 32'h1);

      // load abort while a player read is outstanding
      ram_a = AW'(2); ram_rd = 1'b1; step(); ram_rd = 1'b0;
      check("abort_rd", 32'(mem_rd), 32'h1);
      ld_start = 1'b1; step(); ld_start = 1'b0;
      check("abort_play", 32'(play), 32'h0);
      check("abort_loaded", 32'(tape_loaded), 32'h0);
      ld_wr = 1'b1; ld_addr = '0; ld_data = 8'h55; step(); ld_wr = 1'b0;
      check("abort_no_we", 32'(mem_we), 32'h0);
      check("abort_wait", 32'(ld_wait), 32'h1);
      check("abort_addr_stable", 32'(mem_addr), 32'h2);
      mem_ack = 1'b1; mem_rdata = 8'hEE; step(); mem_ack = 1'b0;
      check("abort_discard", 32'(ram_di), 32'hA5);
      check("abort_rd_done", 32'(mem_rd), 32'h0);
      check("abort_we", 32'(mem_we), 32'h1);
      check("abort_we_addr", 32'(mem_addr), 32'h0);
      check("abort_we_data", 32'(mem_wdata), 32'h55);
      check("abort_bmr", 32'(buff_mem_ready), 32'h0);
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      check("abort_wr_done", 32'(ld_wait), 32'h0);

      // ld_start beats ld_done, then an empty image returns to EMPTY
      ld_start = 1'b1; ld_done = 1'b1; step(); ld_start = 1'b0;
      check("start_beats_done", 32'(rewind), 32'h0);
      step(); ld_done = 1'b0;
      check("empty_no_rewind", 32'(rewind), 32'h0);
      check("empty_not_loaded", 32'(tape_loaded), 32'h0);
      ld_wr = 1'b1; step(); ld_wr = 1'b0;
      check("empty_drop_wr", 32'(ld_wait), 32'h0);

      // reset during an outstanding read, followed by a stray ack
      motor = 1'b0;
      ld_start = 1'b1; step(); ld_start = 1'b0;
      ld_wr = 1'b1; ld_addr = AW'(4); ld_data = 8'h11; step(); ld_wr = 1'b0;
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      ld_done = 1'b1; step(); ld_done = 1'b0;
      step();
      ram_a = AW'(2); ram_rd = 1'b1; step(); ram_rd = 1'b0;
      check("rst_rd_pending", 32'(mem_rd), 32'h1);
      #2 reset_n = 1'b0;
      #1 check("rst_async_flags", 32'(flags), 32'h0);
      step();
      reset_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 8'h77; step(); mem_ack = 1'b0;
      check("rst_stray_flags", 32'(flags), 32'h0);
      check("rst_stray_data", 32'(ram_di), 32'h0);
      step();
      check("rst_no_bmr", 32'(buff_mem_ready), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tape_ctrl.md
Name: tape_ctrl

Overview:
Transport controller and buffer-memory arbiter for the MSX CAS player. It shares one byte-wide buffer memory between the host loader, which writes the CAS image, and the CAS player, which reads it. It sequences the player's play and rewind inputs from load events, the PPI cassette-motor line and a user rewind request. It sits between the loader bridge, the buffer RAM and the tape player.

Parameters:
ADDR_W, 27, buffer address width.
MOTOR_HOLD, 53000, ce_5m3 ticks (~10 ms) motor must stay low before play drops.
AUTO_REWIND, 1, issue rewind automatically after a completed load.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_5m3  in  1  5.37 MHz clock enable
motor  in  1  PPI cassette motor control, active high
user_rewind  in  1  rewind request, level, edge-detected internally
ld_start  in  1  loader pulse: new image begins
ld_wr  in  1  loader byte write strobe
ld_addr  in  ADDR_W  loader write address
ld_data  in  8  loader write data
ld_done  in  1  loader pulse: image complete
ld_wait  out  1  loader must hold its write while high
ram_a  in  ADDR_W  player read address
ram_rd  in  1  player read strobe, single-cycle
ram_di  out  8  read data to player
buff_mem_ready  out  1  player may issue or sample
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_we  out  1  memory write request
mem_rd  out  1  memory read request
mem_rdata  in  8  memory read data
mem_ack  in  1  single-cycle completion of the outstanding request
play  out  1  player run enable
rewind  out  1  player rewind, one-cycle pulse
tape_loaded  out  1  valid image present
tape_end  out  1  player address reached image size

Behaviour:
- Reset values: all outputs 0; state EMPTY; size register 0; no request pending.
- States:
  - EMPTY: ld_start -> LOADING.
  - LOADING: ld_done -> READY, or REWIND if AUTO_REWIND=1.
  - REWIND: rewind=1 for exactly one cycle, then READY.
  - READY: motor high -> PLAYING.
  - PLAYING: motor low for MOTOR_HOLD consecutive ce_5m3 ticks -> READY. Any motor high restarts the hold count. tape_end -> READY.
- user_rewind rising edge in READY or PLAYING -> REWIND. play drops the same cycle. Ignored in EMPTY and LOADING.
- ld_start in any non-LOADING state aborts:
  - play=0 and tape_loaded=0 immediately.
  - An outstanding player read is completed (mem_ack awaited, data discarded), then LOADING.
- play=1 only in PLAYING. tape_loaded=1 in READY, REWIND and PLAYING.
- Memory protocol: at most one outstanding request. mem_rd/mem_we held with stable addr/data until the mem_ack cycle, deasserted the cycle after.
- Loader path:
  - Granted only in LOADING; ld_wr in any other state is dropped.
  - ld_wr issues mem_we. ld_wait=1 from the cycle after ld_wr until mem_ack.
  - Size register <= max(size, ld_addr+1). Cleared on ld_start.
- Player path:
  - buff_mem_ready=1 in READY, REWIND and PLAYING when no read is pending.
  - ram_rd sampled with buff_mem_ready=1 -> mem_rd issued at ram_a; buff_mem_ready=0 from the next cycle.
  - On mem_ack: ram_di<=mem_rdata, buff_mem_ready=1 the following cycle. Latency is mem latency plus 1.
  - ram_rd while a read is pending or while buff_mem_ready=0 is ignored.
- tape_end=1 when ram_a >= size in PLAYING (ADDR_W-bit unsigned compare). Cleared by rewind.
- ld_done without a preceding ld_start is ignored. ld_done with size 0 -> EMPTY.
- Simultaneous events:
  - ld_start beats user_rewind.
  - rewind beats motor.
  - ld_done and ld_start in the same cycle: ld_start wins, and a new load begins.
- Reset mid-request: pending state cleared asynchronously; a late mem_ack after reset is ignored.

Decomposition:
- Package tape_pkg: state enum (EMPTY, LOADING, REWIND, READY, PLAYING), MOTOR_HOLD default, baud-related constants shared with the player.
- One sub-module tape_mem_arb: request mux, pending flag, ld_wait/buff_mem_ready/ram_di generation, driven by a grant select from the FSM.

Test Plan:
- Load 3 bytes at addr 0..2, mem_ack 2 cycles after each write -> three mem_we with data intact; ld_wait high 2 cycles each; ld_done -> rewind pulse once; tape_loaded=1; size=3.
- READY, motor=1 -> play=1 next cycle. Player read at ram_a=1 with mem_ack after 3 cycles -> ram_di=byte1; buff_mem_ready low for 4 cycles.
- PLAYING, motor pulses low for MOTOR_HOLD-1 ticks then high -> play stays 1. Low for MOTOR_HOLD ticks -> play=0.
- ram_a reaches 3 while PLAYING -> tape_end=1, play=0. user_rewind edge -> rewind pulse, tape_end=0.
- ld_start during a pending player read -> no mem_we until mem_ack; ram_di unchanged; state LOADING; tape_loaded=0.
- reset_n low mid-read, then a stray mem_ack -> all outputs 0; no buff_mem_ready pulse.
